// File: rtl/dds_sweep_ctrl_if.sv
// rtl/dds_sweep_ctrl_if.sv - host and DDS control bundle for the sweep scheduler
interface dds_sweep_ctrl_if #(
    parameter int M   = 32,
    parameter int N_W = 16,
    parameter int D_W = 24
);
    logic           ic_start;
    logic           ic_abort;
    logic [M-1:0]   id_f0;
    logic [M-1:0]   id_df;
    logic [N_W-1:0] id_nsteps;
    logic [D_W-1:0] id_dwell;
    logic           ic_zc_sync;
    logic           ic_zero_crossing;
    logic [M-1:0]   od_p_ac;
    logic           oc_rst_ac;
    logic           oc_en_ac;
    logic           oc_val_data;
    logic           oc_busy;
    logic           oc_done;
    logic [N_W-1:0] od_step_idx;

    modport master (
        output ic_start, ic_abort, id_f0, id_df, id_nsteps, id_dwell,
               ic_zc_sync, ic_zero_crossing,
        input  od_p_ac, oc_rst_ac, oc_en_ac, oc_val_data, oc_busy, oc_done,
               od_step_idx
    );

    modport slave (
        input  ic_start, ic_abort, id_f0, id_df, id_nsteps, id_dwell,
               ic_zc_sync, ic_zero_crossing,
        output od_p_ac, oc_rst_ac, oc_en_ac, oc_val_data, oc_busy, oc_done,
               od_step_idx
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - stepped-frequency sweep scheduler driving the DDS control ports
module dds_sweep_ctrl #(
    parameter int M   = 32,
    parameter int N_W = 16,
    parameter int D_W = 24
) (
    input  logic             clk,
    input  logic             ic_rst,
    dds_sweep_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_DWELL  = 3'd2,
        S_ZCWAIT = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [M-1:0]   r_p_ac;
    logic [M-1:0]   r_df;
    logic [N_W-1:0] r_idx;
    logic [N_W-1:0] r_nsteps;
    logic [D_W-1:0] r_dwell_eff;
    logic [D_W-1:0] r_cnt;
    logic           r_zc_sync;

    logic [D_W-1:0] w_dwell_eff;
    logic [D_W-1:0] w_reload;
    logic [D_W-1:0] w_cnt_nxt;
    logic           w_load;
    logic           w_step;
    logic           w_abort;
    logic           w_cnt_zero;
    logic           w_last;

    logic           w_rst_ac;
    logic           w_en;
    logic           w_busy;
    logic           w_done;

    logic [M-1:0]   r_o_p_ac;
    logic [N_W-1:0] r_o_idx;
    logic           r_o_rst_ac;
    logic           r_o_en;
    logic           r_o_busy;
    logic           r_o_done;

    assign w_dwell_eff = (bus.id_dwell == '0) ? D_W'(1) : bus.id_dwell;
    assign w_reload    = r_dwell_eff - D_W'(1);
    assign w_abort     = bus.ic_abort && (r_state != S_IDLE);
    assign w_load      = (r_state == S_IDLE) && bus.ic_start && !bus.ic_abort;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_last      = (r_idx == r_nsteps);

    always_ff @(posedge clk or posedge ic_rst) begin
        if (ic_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_step    = 1'b0;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_next = S_CLR;
                end
            end
            S_CLR: begin
                w_next    = S_DWELL;
                w_cnt_nxt = w_reload;
            end
            S_DWELL: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt = w_reload;
                    if (w_last) begin
                        w_next = S_FIN;
                    end else if (r_zc_sync) begin
                        w_next = S_ZCWAIT;
                    end else begin
                        w_step = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - D_W'(1);
                end
            end
            S_ZCWAIT: begin
                // the counter doubles as a timeout so a lagging or missing crossing cannot stall the sweep
                if (bus.ic_zero_crossing || w_cnt_zero) begin
                    w_step    = 1'b1;
                    w_next    = S_DWELL;
                    w_cnt_nxt = w_reload;
                end else begin
                    w_cnt_nxt = r_cnt - D_W'(1);
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next    = S_IDLE;
            w_step    = 1'b0;
            w_cnt_nxt = r_cnt;
        end
    end

    always_comb begin
        w_rst_ac = (r_state == S_CLR);
        w_en     = (r_state == S_DWELL) || (r_state == S_ZCWAIT);
        w_busy   = (r_state != S_IDLE);
        w_done   = (r_state == S_FIN) && !bus.ic_abort;
    end

    always_ff @(posedge clk or posedge ic_rst) begin
        if (ic_rst) begin
            r_p_ac      <= '0;
            r_df        <= '0;
            r_idx       <= '0;
            r_nsteps    <= '0;
            r_dwell_eff <= '0;
            r_cnt       <= '0;
            r_zc_sync   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_load) begin
                r_p_ac      <= bus.id_f0;
                r_idx       <= '0;
                r_df        <= bus.id_df;
                r_nsteps    <= bus.id_nsteps;
                r_dwell_eff <= w_dwell_eff;
                r_zc_sync   <= bus.ic_zc_sync;
            end else if (w_step) begin
                r_p_ac <= r_p_ac + r_df;
                r_idx  <= r_idx + N_W'(1);
            end
        end
    end

    // tone word and index ride the same output stage as en so they stay aligned
    always_ff @(posedge clk or posedge ic_rst) begin
        if (ic_rst) begin
            r_o_p_ac   <= '0;
            r_o_idx    <= '0;
            r_o_rst_ac <= 1'b0;
            r_o_en     <= 1'b0;
            r_o_busy   <= 1'b0;
            r_o_done   <= 1'b0;
        end else begin
            r_o_p_ac   <= r_p_ac;
            r_o_idx    <= r_idx;
            r_o_rst_ac <= w_rst_ac;
            r_o_en     <= w_en;
            r_o_busy   <= w_busy;
            r_o_done   <= w_done;
        end
    end

    assign bus.od_p_ac     = r_o_p_ac;
    assign bus.od_step_idx = r_o_idx;
    assign bus.oc_rst_ac   = r_o_rst_ac;
    assign bus.oc_en_ac    = r_o_en;
    assign bus.oc_val_data = r_o_en;
    assign bus.oc_busy     = r_o_busy;
    assign bus.oc_done     = r_o_done;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;
    localparam int M   = 32;
    localparam int N_W = 16;
    localparam int D_W = 24;

    logic clk    = 1'b0;
    logic ic_rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.M(M), .N_W(N_W), .D_W(D_W)) bus ();

    dds_sweep_ctrl #(.M(M), .N_W(N_W), .D_W(D_W)) dut (
        .clk    (clk),
        .ic_rst (ic_rst),
        .bus    (bus.slave)
    );

    // start is sampled at edge k; returns just after edge k
    task automatic start_sweep(input logic [M-1:0] f0, input logic [M-1:0] df,
                               input logic [N_W-1:0] n, input logic [D_W-1:0] dw,
                               input logic zc);
        @(negedge clk);
        bus.id_f0      = f0;
        bus.id_df      = df;
        bus.id_nsteps  = n;
        bus.id_dwell   = dw;
        bus.ic_zc_sync = zc;
        bus.ic_start   = 1'b1;
        @(posedge clk);
        #1 bus.ic_start = 1'b0;
    endtask

    task automatic test_reset;
        bus.ic_start = 1'b0; bus.ic_abort = 1'b0; bus.ic_zero_crossing = 1'b0;
        bus.id_f0 = '0; bus.id_df = '0; bus.id_nsteps = '0; bus.id_dwell = '0;
        bus.ic_zc_sync = 1'b0;
        ic_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.od_p_ac, bus.od_step_idx, bus.oc_rst_ac, bus.oc_en_ac, bus.oc_val_data,
             bus.oc_busy, bus.oc_done} !== '0) begin
            errors++;
            $display("FAIL reset_hold: p_ac=%h idx=%0d rst=%b en=%b val=%b busy=%b done=%b, want all 0",
                     bus.od_p_ac, bus.od_step_idx, bus.oc_rst_ac, bus.oc_en_ac,
                     bus.oc_val_data, bus.oc_busy, bus.oc_done);
        end
        ic_rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.oc_busy !== 1'b0 || bus.oc_en_ac !== 1'b0 || bus.oc_rst_ac !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b en=%b rst=%b, want 0 0 0",
                     bus.oc_busy, bus.oc_en_ac, bus.oc_rst_ac);
        end
    endtask

    task automatic test_basic;
        logic [M-1:0] exp_p;
        start_sweep(32'h0100_0000, 32'h0080_0000, 16'd3, 24'd4, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.oc_busy !== 1'b0 || bus.oc_rst_ac !== 1'b0) begin
            errors++;
            $display("FAIL basic_lat0: busy=%b rst=%b, want 0 0", bus.oc_busy, bus.oc_rst_ac);
        end
        @(negedge clk);
        checks++;
        if (bus.oc_rst_ac !== 1'b1 || bus.oc_en_ac !== 1'b0 || bus.oc_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_clr: rst=%b en=%b busy=%b, want 1 0 1",
                     bus.oc_rst_ac, bus.oc_en_ac, bus.oc_busy);
        end
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            exp_p = 32'h0100_0000 + 32'(t / 4) * 32'h0080_0000;
            checks++;
            if (bus.oc_en_ac !== 1'b1 || bus.oc_val_data !== 1'b1 || bus.oc_rst_ac !== 1'b0 ||
                bus.oc_done !== 1'b0 || bus.od_p_ac !== exp_p || bus.od_step_idx !== 16'(t / 4)) begin
                errors++;
                $display("FAIL basic_tone%0d: en=%b val=%b done=%b p_ac=%h idx=%0d, want 1 1 0 %h %0d",
                         t, bus.oc_en_ac, bus.oc_val_data, bus.oc_done, bus.od_p_ac,
                         bus.od_step_idx, exp_p, t / 4);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.oc_done !== 1'b1 || bus.oc_en_ac !== 1'b0 || bus.oc_val_data !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b en=%b val=%b, want 1 0 0",
                     bus.oc_done, bus.oc_en_ac, bus.oc_val_data);
        end
        @(negedge clk);
        checks++;
        if (bus.oc_done !== 1'b0 || bus.oc_busy !== 1'b0 ||
            bus.od_p_ac !== 32'h0280_0000 || bus.od_step_idx !== 16'd3) begin
            errors++;
            $display("FAIL basic_idle_hold: done=%b busy=%b p_ac=%h idx=%0d, want 0 0 02800000 3",
                     bus.oc_done, bus.oc_busy, bus.od_p_ac, bus.od_step_idx);
        end
    endtask

    task automatic test_minimum;
        start_sweep(32'h0000_1234, 32'h0000_0010, 16'd0, 24'd0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.oc_rst_ac !== 1'b1 || bus.oc_en_ac !== 1'b0) begin
            errors++;
            $display("FAIL min_clr: rst=%b en=%b, want 1 0", bus.oc_rst_ac, bus.oc_en_ac);
        end
        @(negedge clk);
        checks++;
        if (bus.oc_en_ac !== 1'b1 || bus.od_p_ac !== 32'h0000_1234 || bus.oc_done !== 1'b0) begin
            errors++;
            $display("FAIL min_tone: en=%b p_ac=%h done=%b, want 1 00001234 0",
                     bus.oc_en_ac, bus.od_p_ac, bus.oc_done);
        end
        @(negedge clk);
        checks++;
        if (bus.oc_done !== 1'b1 || bus.oc_en_ac !== 1'b0) begin
            errors++;
            $display("FAIL min_done: done=%b en=%b, want 1 0", bus.oc_done, bus.oc_en_ac);
        end
        @(negedge clk);
        checks++;
        if (bus.oc_done !== 1'b0 || bus.oc_busy !== 1'b0) begin
            errors++;
            $display("FAIL min_after: done=%b busy=%b, want 0 0", bus.oc_done, bus.oc_busy);
        end
    endtask

    task automatic test_wrap;
        logic [M-1:0] exp_tab [3];
        exp_tab[0] = 32'h0000_0010;
        exp_tab[1] = 32'hFFFF_FFF0;
        exp_tab[2] = 32'hFFFF_FFD0;
        start_sweep(32'h0000_0010, 32'hFFFF_FFE0, 16'd2, 24'd2, 1'b0);
        repeat (2) @(negedge clk);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            checks++;
            if (bus.oc_en_ac !== 1'b1 || bus.od_p_ac !== exp_tab[t / 2] ||
                bus.od_step_idx !== 16'(t / 2)) begin
                errors++;
                $display("FAIL wrap_tone%0d: en=%b p_ac=%h idx=%0d, want 1 %h %0d",
                         t, bus.oc_en_ac, bus.od_p_ac, bus.od_step_idx, exp_tab[t / 2], t / 2);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.oc_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: done=%b, want 1", bus.oc_done);
        end
    endtask

    // sample s is taken at the negedge after edge k+s
    task automatic test_zc_sync(input bit pulse);
        logic [M-1:0] exp_p;
        int           last_en;
        int           step_s;
        step_s  = pulse ? 13 : 18;
        last_en = pulse ? 20 : 25;
        start_sweep(32'h0400_0000, 32'h0100_0000, 16'd1, 24'd8, 1'b1);
        @(negedge clk);
        for (int s = 1; s <= last_en + 1; s++) begin
            @(negedge clk);
            if (s >= 2) begin
                exp_p = (s >= step_s) ? 32'h0500_0000 : 32'h0400_0000;
                checks++;
                if (s <= last_en) begin
                    if (bus.oc_en_ac !== 1'b1 || bus.od_p_ac !== exp_p ||
                        bus.od_step_idx !== ((s >= step_s) ? 16'd1 : 16'd0) || bus.oc_done !== 1'b0) begin
                        errors++;
                        $display("FAIL zc%0d_s%0d: en=%b p_ac=%h idx=%0d done=%b, want 1 %h %0d 0",
                                 pulse, s, bus.oc_en_ac, bus.od_p_ac, bus.od_step_idx,
                                 bus.oc_done, exp_p, (s >= step_s) ? 1 : 0);
                    end
                end else if (bus.oc_done !== 1'b1 || bus.oc_en_ac !== 1'b0) begin
                    errors++;
                    $display("FAIL zc%0d_done: done=%b en=%b, want 1 0", pulse, bus.oc_done, bus.oc_en_ac);
                end
            end
            if (pulse && s == 11) bus.ic_zero_crossing = 1'b1;
            if (s == 12) bus.ic_zero_crossing = 1'b0;
        end
    endtask

    task automatic test_abort;
        start_sweep(32'h0A00_0000, 32'h0100_0000, 16'd3, 24'd10, 1'b0);
        @(negedge clk);
        for (int s = 1; s <= 7; s++) begin
            @(negedge clk);
            if (s >= 2 && s <= 6) begin
                checks++;
                if (bus.oc_en_ac !== 1'b1 || bus.od_p_ac !== 32'h0A00_0000 || bus.od_step_idx !== 16'd0) begin
                    errors++;
                    $display("FAIL abort_run_s%0d: en=%b p_ac=%h idx=%0d, want 1 0a000000 0",
                             s, bus.oc_en_ac, bus.od_p_ac, bus.od_step_idx);
                end
            end
            if (s == 3) begin
                bus.ic_start = 1'b1; bus.id_f0 = 32'hDEAD_0000; bus.id_df = '0;
            end
            if (s == 4) bus.ic_start = 1'b0;
            if (s == 5) bus.ic_abort = 1'b1;
            if (s == 6) bus.ic_abort = 1'b0;
        end
        checks++;
        if (bus.oc_en_ac !== 1'b0 || bus.oc_val_data !== 1'b0 || bus.oc_busy !== 1'b0 ||
            bus.oc_done !== 1'b0 || bus.od_p_ac !== 32'h0A00_0000 || bus.od_step_idx !== 16'd0) begin
            errors++;
            $display("FAIL abort_stop: en=%b val=%b busy=%b done=%b p_ac=%h idx=%0d, want 0 0 0 0 0a000000 0",
                     bus.oc_en_ac, bus.oc_val_data, bus.oc_busy, bus.oc_done, bus.od_p_ac, bus.od_step_idx);
        end
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            checks++;
            if (bus.oc_done !== 1'b0 || bus.oc_busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet_%0d: done=%b busy=%b, want 0 0", s, bus.oc_done, bus.oc_busy);
            end
        end
        bus.ic_start = 1'b1;
        bus.ic_abort = 1'b1;
        @(negedge clk);
        bus.ic_start = 1'b0;
        bus.ic_abort = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (bus.oc_busy !== 1'b0 || bus.oc_rst_ac !== 1'b0) begin
                errors++;
                $display("FAIL abort_start_idle_%0d: busy=%b rst=%b, want 0 0", s, bus.oc_busy, bus.oc_rst_ac);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [M-1:0] exp_p;
        start_sweep(32'h0100_0000, 32'h0080_0000, 16'd3, 24'd4, 1'b0);
        repeat (9) @(negedge clk);
        checks++;
        if (bus.oc_en_ac !== 1'b1 || bus.od_p_ac !== 32'h0180_0000) begin
            errors++;
            $display("FAIL rstmid_pre: en=%b p_ac=%h, want 1 01800000", bus.oc_en_ac, bus.od_p_ac);
        end
        #2 ic_rst = 1'b1;
        #1;
        checks++;
        if ({bus.od_p_ac, bus.od_step_idx, bus.oc_rst_ac, bus.oc_en_ac, bus.oc_val_data,
             bus.oc_busy, bus.oc_done} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: p_ac=%h idx=%0d rst=%b en=%b busy=%b done=%b, want all 0",
                     bus.od_p_ac, bus.od_step_idx, bus.oc_rst_ac, bus.oc_en_ac, bus.oc_busy, bus.oc_done);
        end
        @(negedge clk);
        ic_rst = 1'b0;
        start_sweep(32'h0000_0100, 32'h0000_0100, 16'd1, 24'd2, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.oc_rst_ac !== 1'b1 || bus.od_p_ac !== 32'h0000_0100) begin
            errors++;
            $display("FAIL rstmid_clr: rst=%b p_ac=%h, want 1 00000100", bus.oc_rst_ac, bus.od_p_ac);
        end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            exp_p = (t < 2) ? 32'h0000_0100 : 32'h0000_0200;
            checks++;
            if (bus.oc_en_ac !== 1'b1 || bus.od_p_ac !== exp_p || bus.od_step_idx !== 16'(t / 2)) begin
                errors++;
                $display("FAIL rstmid_tone%0d: en=%b p_ac=%h idx=%0d, want 1 %h %0d",
                         t, bus.oc_en_ac, bus.od_p_ac, bus.od_step_idx, exp_p, t / 2);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.oc_done !== 1'b1 || bus.oc_en_ac !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_done: done=%b en=%b, want 1 0", bus.oc_done, bus.oc_en_ac);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_minimum();
        test_wrap();
        test_zc_sync(1'b1);
        test_zc_sync(1'b0);
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
